// File: rtl/xy_pixel_writer.sv
// xy_pixel_writer
//   Takes 11-bit x/y blob coordinates from the IR camera block, rejects no-blob and
//   out-of-range samples, averages 2**AVG_LOG2 consecutive valid samples, scales the
//   result from camera space to screen space by 5/8 and issues single-pixel write
//   requests to the framebuffer arbiter while the pen is down.
// Ports
//   clk         system clock
//   reset       synchronous, active-low reset
//   xy_valid    1-cycle strobe: x/y carry a new camera sample
//   x, y        camera coordinates; 1023 means no blob
//   pen_down    debounced pen button, level
//   wr_req      write request to the arbiter, held until wr_ack
//   wr_addr     linear pixel address, stable while wr_req is high
//   wr_data     pixel data (COLOUR), stable while wr_req is high
//   wr_ack      arbiter accepts the request in this cycle
//   busy        high while computing or requesting (state != ACC)
//   drop_count  samples discarded while busy, saturating at 255
module xy_pixel_writer #(
  parameter int unsigned       SCREEN_W = 640,
  parameter int unsigned       CAM_W    = 1024,
  parameter int unsigned       CAM_H    = 768,
  parameter int unsigned       AVG_LOG2 = 2,
  parameter int unsigned       ADDR_W   = 19,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] COLOUR   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xy_valid,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              pen_down,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic [7:0]        drop_count
);

  localparam int unsigned AccW = 11 + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {StAcc, StCalc, StReq} state_e;

  state_e              state_q, state_d;
  logic [AccW-1:0]     sum_x_q, sum_x_d;
  logic [AccW-1:0]     sum_y_q, sum_y_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pen_q, pen_d;
  logic                last_valid_q, last_valid_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [7:0]          drop_q, drop_d;
  logic                busy_q, busy_d;

  logic                sample_ok;
  logic [10:0]         xa, ya;
  logic [12:0]         x_prod, y_prod;
  logic [9:0]          xs, ys;
  logic [ADDR_W-1:0]   calc_addr;

  assign sample_ok = (x != 11'd1023) && (y != 11'd1023) &&
                     (32'(x) < CAM_W) && (32'(y) < CAM_H);

  // Averaging and 5/8 scaling; 1022*5 fits in 13 bits so no product bit is lost.
  assign xa     = 11'(sum_x_q >> AVG_LOG2);
  assign ya     = 11'(sum_y_q >> AVG_LOG2);
  assign x_prod = {2'b00, xa} * 13'd5;
  assign y_prod = {2'b00, ya} * 13'd5;
  assign xs     = x_prod[12:3];
  assign ys     = y_prod[12:3];

  generate
    if (SCREEN_W == 640) begin : g_addr_640
      // 640 = 512 + 128, so the row multiply reduces to two shifts.
      assign calc_addr = (ADDR_W'(ys) << 9) + (ADDR_W'(ys) << 7) + ADDR_W'(xs);
    end else begin : g_addr_mul
      assign calc_addr = ADDR_W'(32'(ys) * SCREEN_W + 32'(xs));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    cnt_d        = cnt_q;
    pen_d        = pen_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    drop_d       = drop_q;

    if (xy_valid && (state_q != StAcc) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      StAcc: begin
        if (xy_valid) begin
          if (sample_ok) begin
            sum_x_d = sum_x_q + AccW'(x);
            sum_y_d = sum_y_q + AccW'(y);
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              pen_d   = pen_down;
              state_d = StCalc;
            end
          end else begin
            // A no-blob sample breaks the run; partial averages are discarded.
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
          end
        end
      end
      StCalc: begin
        sum_x_d = '0;
        sum_y_d = '0;
        cnt_d   = '0;
        state_d = StAcc;
        if (!pen_q) begin
          // Pen lifted: the next stroke must draw even at the same pixel.
          last_valid_d = 1'b0;
        end else if (!(last_valid_q && (calc_addr == last_addr_q))) begin
          wr_addr_d = calc_addr;
          wr_data_d = COLOUR;
          wr_req_d  = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (wr_ack) begin
          wr_req_d     = 1'b0;
          last_addr_d  = wr_addr_q;
          last_valid_d = 1'b1;
          state_d      = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase

    busy_d = (state_d != StAcc);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StAcc;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      cnt_q        <= '0;
      pen_q        <= 1'b0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      cnt_q        <= cnt_d;
      pen_q        <= pen_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_xy_pixel_writer.sv
// Directed bench for xy_pixel_writer: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_xy_pixel_writer;

  logic        clk;
  logic        reset;
  logic        xy_valid;
  logic [10:0] x;
  logic [10:0] y;
  logic        pen_down;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        busy;
  logic [7:0]  drop_count;

  int n_total = 0;
  int n_bad   = 0;

  xy_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .xy_valid   (xy_valid),
    .x          (x),
    .y          (y),
    .pen_down   (pen_down),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    xy_valid = 1'b0;
    wr_ack   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_group(input int n, input logic [10:0] xx, input logic [10:0] yy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      xy_valid = 1'b1;
      x        = xx;
      y        = yy;
    end
    @(negedge clk);
    xy_valid = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (wr_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_req(input string tag);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(wr_req), 0);
    check({tag, "_busy_drop"}, 32'(busy), 0);
  endtask

  initial begin
    bit          seen;
    bit          stable;
    logic [18:0] held_addr;

    reset    = 1'b0;
    xy_valid = 1'b0;
    x        = '0;
    y        = '0;
    pen_down = 1'b0;
    wr_ack   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    check("rst_req", 32'(wr_req), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_count), 0);

    // Centre point, ack three cycles after the request.
    pen_down = 1'b1;
    send_group(4, 11'd512, 11'd384);
    wait_req(10, seen);
    check("t1_req", 32'(seen), 1);
    check("t1_addr", 32'(wr_addr), 153920);
    check("t1_data", 32'(wr_data), 8'hFF);
    check("t1_busy", 32'(busy), 1);
    repeat (3) @(negedge clk);
    check("t1_hold", 32'(wr_req), 1);
    ack_req("t1");

    // An invalid sample restarts the average.
    do_reset();
    send_group(2, 11'd512, 11'd384);
    send_group(1, 11'd1023, 11'd1023);
    send_group(3, 11'd512, 11'd384);
    wait_req(6, seen);
    check("t2_early", 32'(seen), 0);
    send_group(1, 11'd512, 11'd384);
    wait_req(10, seen);
    check("t2_req", 32'(seen), 1);
    check("t2_addr", 32'(wr_addr), 153920);
    ack_req("t2");

    // Out-of-range y counts as invalid: no write from this group.
    do_reset();
    send_group(4, 11'd100, 11'd800);
    wait_req(10, seen);
    check("t2b_noreq", 32'(seen), 0);

    // Corner point; a repeat of the same pixel is suppressed.
    do_reset();
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t3_req", 32'(seen), 1);
    check("t3_addr", 32'(wr_addr), 307198);
    ack_req("t3");
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t3_dup", 32'(seen), 0);

    // Pen lifted on group 2 clears the duplicate filter.
    do_reset();
    pen_down = 1'b1;
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t4_g1", 32'(seen), 1);
    check("t4_g1_addr", 32'(wr_addr), 307198);
    ack_req("t4g1");
    pen_down = 1'b0;
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t4_g2", 32'(seen), 0);
    pen_down = 1'b1;
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t4_g3", 32'(seen), 1);
    check("t4_g3_addr", 32'(wr_addr), 307198);
    ack_req("t4g3");

    // Ack withheld while samples stream in every cycle.
    do_reset();
    send_group(4, 11'd512, 11'd384);
    wait_req(10, seen);
    check("t5_req", 32'(seen), 1);
    held_addr = wr_addr;
    stable    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      xy_valid = 1'b1;
      x        = 11'd100;
      y        = 11'd100;
      if (!wr_req || wr_addr != held_addr || wr_data != 8'hFF) stable = 1'b0;
    end
    @(negedge clk);
    xy_valid = 1'b0;
    check("t5_stable", 32'(stable), 1);
    check("t5_addr", 32'(wr_addr), 153920);
    check("t5_drop", 32'(drop_count), 255);
    ack_req("t5");
    check("t5_drop_hold", 32'(drop_count), 255);

    // Reset in the middle of a request abandons it and clears last_valid.
    send_group(4, 11'd1022, 11'd767);
    wait_req(10, seen);
    check("t6_req", 32'(seen), 1);
    check("t6_addr", 32'(wr_addr), 307198);
    do_reset();
    @(negedge clk);
    check("t6_rst_req", 32'(wr_req), 0);
    check("t6_rst_drop", 32'(drop_count), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_addr", 32'(wr_addr), 0);
    send_group(4, 11'd512, 11'd384);
    wait_req(10, seen);
    check("t6_after", 32'(seen), 1);
    check("t6_after_addr", 32'(wr_addr), 153920);
    ack_req("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
